// File: rtl/demux_rx4_reassembler_if.sv
// Bundled serial-in / reassembled-out signals of the 4-lane receive reassembler.
// The master side drives the serial byte stream; the slave side is the reassembler.
interface demux_rx4_reassembler_if #(
    parameter int COUNT_W = 8
);
    logic [7:0]         dataIn;
    logic               validIn;
    logic               sync;
    logic [7:0]         dataOut0;
    logic [7:0]         dataOut1;
    logic [7:0]         dataOut2;
    logic [7:0]         dataOut3;
    logic               validOut0;
    logic               validOut1;
    logic               validOut2;
    logic               validOut3;
    logic               groupValid;
    logic [1:0]         laneSel;
    logic [COUNT_W-1:0] groupCount;

    modport master (
        output dataIn, validIn, sync,
        input  dataOut0, dataOut1, dataOut2, dataOut3,
        input  validOut0, validOut1, validOut2, validOut3,
        input  groupValid, laneSel, groupCount
    );

    modport slave (
        input  dataIn, validIn, sync,
        output dataOut0, dataOut1, dataOut2, dataOut3,
        output validOut0, validOut1, validOut2, validOut3,
        output groupValid, laneSel, groupCount
    );
endinterface

// File: rtl/demux_rx4_reassembler.sv
// Receive-side reassembler for a 4:1 serialized byte stream: a free-running lane
// counter captures lanes 0..2 into hold registers and delivers all four with lane 3.
module demux_rx4_reassembler #(
    parameter int         COUNT_W      = 8,
    parameter logic [7:0] INVALID_FILL = 8'h00
) (
    input logic                    clk,
    input logic                    reset,
    demux_rx4_reassembler_if.slave bus
);

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_t;

    function automatic logic [7:0] fill_lane(input logic [7:0] d, input logic v);
        return v ? d : INVALID_FILL;
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (c == {COUNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    lane_t              lane_p0;
    lane_t              lane_next;
    logic               deliver;
    logic [7:0]         hold_data_p0 [3];
    logic [2:0]         hold_vld_p0;
    logic [3:0]         grp_vld;
    logic [7:0]         data_out_p1 [4];
    logic [3:0]         vld_out_p1;
    logic               group_vld_p1;
    logic [COUNT_W-1:0] count_p1;

    // Stage p0: lane pointer; delivery happens on the lane-3 slot unless sync realigns
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_p0 <= LANE0;
        end else begin
            lane_p0 <= lane_next;
        end
    end

    always_comb begin
        lane_next = LANE0;
        deliver   = 1'b0;
        if (!bus.sync) begin
            case (lane_p0)
                LANE0:   lane_next = LANE1;
                LANE1:   lane_next = LANE2;
                LANE2:   lane_next = LANE3;
                LANE3: begin
                    lane_next = LANE0;
                    deliver   = 1'b1;
                end
                default: lane_next = LANE0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_vld_p0     <= 3'b000;
            hold_data_p0[0] <= 8'h00;
            hold_data_p0[1] <= 8'h00;
            hold_data_p0[2] <= 8'h00;
        end else if (bus.sync || deliver) begin
            hold_vld_p0 <= 3'b000;
        end else begin
            case (lane_p0)
                LANE0: begin
                    hold_data_p0[0] <= bus.dataIn;
                    hold_vld_p0[0]  <= bus.validIn;
                end
                LANE1: begin
                    hold_data_p0[1] <= bus.dataIn;
                    hold_vld_p0[1]  <= bus.validIn;
                end
                LANE2: begin
                    hold_data_p0[2] <= bus.dataIn;
                    hold_vld_p0[2]  <= bus.validIn;
                end
                default: ;
            endcase
        end
    end

    // Lane 3 bypasses the hold registers so the group leaves on the edge it completes
    assign grp_vld = {bus.validIn, hold_vld_p0};

    // Stage p1: delivered group, held stable between deliveries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_p1[0] <= 8'h00;
            data_out_p1[1] <= 8'h00;
            data_out_p1[2] <= 8'h00;
            data_out_p1[3] <= 8'h00;
            vld_out_p1     <= 4'b0000;
            group_vld_p1   <= 1'b0;
            count_p1       <= '0;
        end else begin
            group_vld_p1 <= 1'b0;
            if (deliver) begin
                data_out_p1[0] <= fill_lane(hold_data_p0[0], hold_vld_p0[0]);
                data_out_p1[1] <= fill_lane(hold_data_p0[1], hold_vld_p0[1]);
                data_out_p1[2] <= fill_lane(hold_data_p0[2], hold_vld_p0[2]);
                data_out_p1[3] <= fill_lane(bus.dataIn, bus.validIn);
                vld_out_p1     <= grp_vld;
                group_vld_p1   <= |grp_vld;
                if (|grp_vld) begin
                    count_p1 <= sat_inc(count_p1);
                end
            end
        end
    end

    assign bus.laneSel    = lane_p0;
    assign bus.dataOut0   = data_out_p1[0];
    assign bus.dataOut1   = data_out_p1[1];
    assign bus.dataOut2   = data_out_p1[2];
    assign bus.dataOut3   = data_out_p1[3];
    assign bus.validOut0  = vld_out_p1[0];
    assign bus.validOut1  = vld_out_p1[1];
    assign bus.validOut2  = vld_out_p1[2];
    assign bus.validOut3  = vld_out_p1[3];
    assign bus.groupValid = group_vld_p1;
    assign bus.groupCount = count_p1;

endmodule

// File: tb/tb_demux_rx4_reassembler.sv
// Directed bench: two reassemblers (8-bit and 2-bit group counters) share one
// stimulus stream; a vector table covers steady-state behaviour, hand sequences the rest.
module tb_demux_rx4_reassembler;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    demux_rx4_reassembler_if #(.COUNT_W(8)) b8 ();
    demux_rx4_reassembler_if #(.COUNT_W(2)) b2 ();

    demux_rx4_reassembler #(.COUNT_W(8), .INVALID_FILL(8'h00)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    demux_rx4_reassembler #(.COUNT_W(2), .INVALID_FILL(8'h00)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        s;
        logic [1:0]  lane;
        logic        gv;
        logic [31:0] dout;
        logic [3:0]  vout;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [29];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic s);
        b8.dataIn  = d;
        b8.validIn = v;
        b8.sync    = s;
        b2.dataIn  = d;
        b2.validIn = v;
        b2.sync    = s;
    endtask

    task automatic check_all(input string tag, input logic [1:0] lane, input logic gv,
                             input logic [31:0] dout, input logic [3:0] vout,
                             input logic [7:0] cnt);
        logic [7:0] cnt2;
        cnt2 = (cnt > 8'd3) ? 8'd3 : cnt;
        check({tag, " lane8"}, 32'(b8.laneSel), 32'(lane));
        check({tag, " gv8"}, 32'(b8.groupValid), 32'(gv));
        check({tag, " dout8"}, {b8.dataOut0, b8.dataOut1, b8.dataOut2, b8.dataOut3}, dout);
        check({tag, " vout8"}, 32'({b8.validOut0, b8.validOut1, b8.validOut2, b8.validOut3}), 32'(vout));
        check({tag, " cnt8"}, 32'(b8.groupCount), 32'(cnt));
        check({tag, " lane2"}, 32'(b2.laneSel), 32'(lane));
        check({tag, " gv2"}, 32'(b2.groupValid), 32'(gv));
        check({tag, " dout2"}, {b2.dataOut0, b2.dataOut1, b2.dataOut2, b2.dataOut3}, dout);
        check({tag, " vout2"}, 32'({b2.validOut0, b2.validOut1, b2.validOut2, b2.validOut3}), 32'(vout));
        check({tag, " cnt2"}, 32'(b2.groupCount), 32'(cnt2));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //            d      v     s     lane  gv    dout          vout     cnt
        tbl[0]  = '{8'hA0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h00000000, 4'b0000, 8'd0};
        tbl[1]  = '{8'hA1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h00000000, 4'b0000, 8'd0};
        tbl[2]  = '{8'hA2, 1'b1, 1'b0, 2'd3, 1'b0, 32'h00000000, 4'b0000, 8'd0};
        tbl[3]  = '{8'hA3, 1'b1, 1'b0, 2'd0, 1'b1, 32'hA0A1A2A3, 4'b1111, 8'd1};
        tbl[4]  = '{8'h11, 1'b1, 1'b0, 2'd1, 1'b0, 32'hA0A1A2A3, 4'b1111, 8'd1};
        tbl[5]  = '{8'h22, 1'b0, 1'b0, 2'd2, 1'b0, 32'hA0A1A2A3, 4'b1111, 8'd1};
        tbl[6]  = '{8'h33, 1'b1, 1'b0, 2'd3, 1'b0, 32'hA0A1A2A3, 4'b1111, 8'd1};
        tbl[7]  = '{8'h44, 1'b0, 1'b0, 2'd0, 1'b1, 32'h11003300, 4'b1010, 8'd2};
        tbl[8]  = '{8'hFF, 1'b0, 1'b0, 2'd1, 1'b0, 32'h11003300, 4'b1010, 8'd2};
        tbl[9]  = '{8'hFF, 1'b0, 1'b0, 2'd2, 1'b0, 32'h11003300, 4'b1010, 8'd2};
        tbl[10] = '{8'hFF, 1'b0, 1'b0, 2'd3, 1'b0, 32'h11003300, 4'b1010, 8'd2};
        tbl[11] = '{8'hFF, 1'b0, 1'b0, 2'd0, 1'b0, 32'h00000000, 4'b0000, 8'd2};
        tbl[12] = '{8'h55, 1'b1, 1'b0, 2'd1, 1'b0, 32'h00000000, 4'b0000, 8'd2};
        tbl[13] = '{8'h66, 1'b1, 1'b0, 2'd2, 1'b0, 32'h00000000, 4'b0000, 8'd2};
        tbl[14] = '{8'h77, 1'b1, 1'b1, 2'd0, 1'b0, 32'h00000000, 4'b0000, 8'd2};
        tbl[15] = '{8'h01, 1'b1, 1'b0, 2'd1, 1'b0, 32'h00000000, 4'b0000, 8'd2};
        tbl[16] = '{8'h02, 1'b1, 1'b0, 2'd2, 1'b0, 32'h00000000, 4'b0000, 8'd2};
        tbl[17] = '{8'h03, 1'b1, 1'b0, 2'd3, 1'b0, 32'h00000000, 4'b0000, 8'd2};
        tbl[18] = '{8'h04, 1'b1, 1'b0, 2'd0, 1'b1, 32'h01020304, 4'b1111, 8'd3};
        tbl[19] = '{8'hB1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h01020304, 4'b1111, 8'd3};
        tbl[20] = '{8'hB2, 1'b1, 1'b0, 2'd2, 1'b0, 32'h01020304, 4'b1111, 8'd3};
        tbl[21] = '{8'hB3, 1'b1, 1'b0, 2'd3, 1'b0, 32'h01020304, 4'b1111, 8'd3};
        tbl[22] = '{8'hB4, 1'b1, 1'b1, 2'd0, 1'b0, 32'h01020304, 4'b1111, 8'd3};
        tbl[23] = '{8'hC0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h01020304, 4'b1111, 8'd3};
        tbl[24] = '{8'hC1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h01020304, 4'b1111, 8'd3};
        tbl[25] = '{8'hD0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h01020304, 4'b1111, 8'd3};
        tbl[26] = '{8'hD1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h01020304, 4'b1111, 8'd3};
        tbl[27] = '{8'hD2, 1'b0, 1'b0, 2'd3, 1'b0, 32'h01020304, 4'b1111, 8'd3};
        tbl[28] = '{8'hD3, 1'b1, 1'b0, 2'd0, 1'b1, 32'h000000D3, 4'b0001, 8'd4};

        reset = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 2'd0, 1'b0, 32'h0, 4'b0000, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].d, tbl[i].v, tbl[i].s);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].lane, tbl[i].gv, tbl[i].dout,
                      tbl[i].vout, tbl[i].cnt);
            @(negedge clk);
        end

        // Asynchronous reset between edges in the middle of a group
        drive(8'hE0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(8'hE1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", 2'd0, 1'b0, 32'h0, 4'b0000, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // Five full groups after release: 8-bit counter 1..5, 2-bit saturates at 3
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                drive(8'(g * 16 + k), 1'b1, 1'b0);
                @(posedge clk);
                #1;
                if (k == 3) begin
                    check_all($sformatf("grp%0d", g), 2'd0, 1'b1,
                              {8'(g * 16), 8'(g * 16 + 1), 8'(g * 16 + 2), 8'(g * 16 + 3)},
                              4'b1111, 8'(g + 1));
                end else begin
                    check($sformatf("grp%0d lane%0d", g, k), 32'(b8.laneSel), 32'(k + 1));
                    check($sformatf("grp%0d gvlow%0d", g, k), 32'(b2.groupValid), 32'd0);
                end
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_rx4_reassembler.md
Name: demux_rx4_reassembler

Overview:
- Single-clock receive-side counterpart of the two-level 4→2→1 mux chain.
- Takes the serialized 8-bit byte stream (dataIn/validIn) that the mux chain produces, one lane per cycle in order 0,1,2,3.
- Runs its own free-running lane counter instead of external selector inputs.
- Reassembles each 4-byte group and presents all four lanes together, with per-lane valids, a group strobe and a saturating group counter.

Parameters:
- COUNT_W, 8, width of groupCount.
- INVALID_FILL, 8'h00, value driven on dataOutk when lane k was invalid in the delivered group.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- dataIn  input  8  serialized byte for the current lane.
- validIn  input  1  dataIn is valid for the current lane.
- sync  input  1  synchronous realign: forces lane counter to 0 and discards the partial group.
- dataOut0..dataOut3  output  8 each  reassembled lane bytes.
- validOut0..validOut3  output  1 each  per-lane valid of the delivered group.
- groupValid  output  1  one-cycle strobe: a group was delivered this cycle with at least one valid lane.
- laneSel  output  2  current lane pointer (the lane sampled at the next edge).
- groupCount  output  COUNT_W  number of delivered groups with groupValid, saturating.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-group):
  - laneSel=0; hold registers and hold-valid bits = 0.
  - dataOut0..3=0, validOut0..3=0, groupValid=0, groupCount=0.
- Lane counter:
  - When sync=0, laneSel increments by 1 every cycle, wrapping 3→0.
  - The counter advances whether or not validIn=1, because the mux chain emits a slot per lane every cycle.
- Capture, laneSel=k, k in 0..2: holdData[k] <= dataIn; holdValid[k] <= validIn.
- Group delivery, at the edge where laneSel=3 and sync=0:
  - For k=0..2: validOutk <= holdValid[k]. dataOutk <= holdData[k] if holdValid[k], else INVALID_FILL.
  - Lane 3 bypasses the hold: validOut3 <= validIn; dataOut3 <= dataIn if validIn, else INVALID_FILL.
  - holdValid[0..2] <= 0.
  - groupValid <= OR of the four valids.
  - groupCount increments if groupValid is set, saturating at all-ones.
- Edges where no group is delivered:
  - groupValid <= 0.
  - dataOut/validOut hold their previous values, so they are stable for 4 cycles.
- Latency:
  - A lane-0 byte sampled at edge E appears on dataOut0 after edge E+3.
  - A lane-3 byte appears after the same edge it is sampled on.
- sync=1 at an edge:
  - laneSel <= 0; holdValid[0..2] <= 0; groupValid <= 0.
  - dataOut/validOut/groupCount unchanged; the current input byte is dropped.
  - sync has priority over delivery when laneSel=3.
  - sync held high keeps laneSel=0 and delivers nothing.
- All-invalid group:
  - Outputs update to INVALID_FILL with validOutk=0.
  - groupValid stays 0; count unchanged.
- groupCount saturation: at all-ones it stays at all-ones; groupValid still pulses.

Test Plan:
- Reset, then stream lanes 0..3 = 8'hA0,8'hA1,8'hA2,8'hA3, all valid → after the 4th edge: dataOut0..3=A0..A3, validOut=1111, groupValid pulses 1 cycle, groupCount=1; outputs hold for 4 cycles.
- Group with validIn pattern 1,0,1,0 and bytes 11,22,33,44 → dataOut=11,00,33,00, validOut0..3=1,0,1,0, groupValid=1.
- Four all-invalid slots → all dataOut=00, all validOut=0, groupValid=0, groupCount unchanged.
- Lanes 0,1 sent (55,66), then sync=1 with laneSel=2 → laneSel=0 next cycle; the following full group 01,02,03,04 delivers exactly 01..04 with no 55/66 leakage.
- Reset asserted asynchronously mid-group (laneSel=2, between edges) → all outputs and laneSel go to 0 immediately without a clock edge; the first group after release is delivered correctly.
- COUNT_W=2, deliver 5 valid groups → groupCount reads 1,2,3,3,3.
